// File: rtl/condicionador_botao_pkg.sv
// rtl/condicionador_botao_pkg.sv - shared types and defaults for the button conditioner
package condicionador_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ESPERA = 2'd1,
        REPETE = 2'd2
    } estado_t;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int REPEAT_DELAY_DEF    = 16;
    localparam int REPEAT_PERIOD_DEF   = 8;
    localparam int REPEAT_EN_DEF       = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/condicionador_botao_debouncer_sinc.sv
// rtl/condicionador_botao_debouncer_sinc.sv - 2-flop synchronizer plus counter debouncer
module debouncer_sinc
    import condicionador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic botao,
    output logic estavel
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          estavel_q, estavel_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        estavel_d = estavel_q;
        cnt_d     = '0;
        if (s2_q != estavel_q) begin
            if (cnt_q == CNT_MAX) begin
                estavel_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            estavel_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= botao;
            s2_q      <= s1_q;
            estavel_q <= estavel_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state level: the parent registers it, so its FSM can react on the flip edge itself.
    assign estavel = estavel_d;

endmodule

// File: rtl/condicionador_botao.sv
// rtl/condicionador_botao.sv - debounced button to single-cycle press/auto-repeat pulses
module condicionador_botao
    import condicionador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter int REPEAT_EN       = REPEAT_EN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic botao,
    output logic pulso,
    output logic estavel,
    output logic repetindo
);

    localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [TW-1:0] DELAY_MAX  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_MAX = TW'(REPEAT_PERIOD - 1);

    logic          estavel_d, estavel_q;
    logic          pulso_d, pulso_q;
    logic          repetindo_d, repetindo_q;
    logic [TW-1:0] timer_d, timer_q;
    estado_t       estado_d, estado_q;
    logic          sobe, desce;

    debouncer_sinc #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .reset  (reset),
        .botao  (botao),
        .estavel(estavel_d)
    );

    assign sobe  = estavel_d & ~estavel_q;
    assign desce = ~estavel_d & estavel_q;

    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q;
        pulso_d  = 1'b0;
        // Release wins over everything, including a repeat expiring on the same edge.
        if (desce) begin
            estado_d = OCIOSO;
            timer_d  = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (sobe) begin
                        pulso_d  = 1'b1;
                        estado_d = ESPERA;
                        timer_d  = '0;
                    end
                end
                ESPERA: begin
                    if (REPEAT_EN != 0) begin
                        if (timer_q == DELAY_MAX) begin
                            pulso_d  = 1'b1;
                            estado_d = REPETE;
                            timer_d  = '0;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                REPETE: begin
                    if (timer_q == PERIOD_MAX) begin
                        pulso_d = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    estado_d = OCIOSO;
                    timer_d  = '0;
                end
            endcase
        end
        repetindo_d = (estado_d == REPETE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            timer_q     <= '0;
            estavel_q   <= 1'b0;
            pulso_q     <= 1'b0;
            repetindo_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            timer_q     <= timer_d;
            estavel_q   <= estavel_d;
            pulso_q     <= pulso_d;
            repetindo_q <= repetindo_d;
        end
    end

    assign pulso     = pulso_q;
    assign estavel   = estavel_q;
    assign repetindo = repetindo_q;

endmodule
